// File: rtl/image_cell_feeder.sv
// Sequencer feeding the cell processor: latches per-job opcode/user input, issues source
// cell pairs, captures processedCell after PROC_LAT edges into a credit-guarded result FIFO.
module image_cell_feeder #(
   parameter int unsigned CELL_W     = 8,
   parameter int unsigned LEN_W      = 16,
   parameter int unsigned PROC_LAT   = 2,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned OPC_W      = 4,
   parameter int unsigned USER_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [OPC_W-1:0]  job_opcode,
   input  logic [USER_W-1:0] job_user,
   input  logic [LEN_W-1:0]  job_len,
   output logic              busy,
   output logic              done,
   input  logic              src_valid,
   output logic              src_ready,
   input  logic [CELL_W-1:0] src_a,
   input  logic [CELL_W-1:0] src_b,
   output logic [CELL_W-1:0] cellA,
   output logic [CELL_W-1:0] cellB,
   output logic [USER_W-1:0] userInputA,
   output logic [OPC_W-1:0]  opcode,
   input  logic [CELL_W-1:0] processedCell,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [CELL_W-1:0] res_data,
   output logic              res_last
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + PROC_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t              r_state, w_next;
   logic [LEN_W-1:0]    r_len, r_issued, r_popped, r_capidx;
   logic [PROC_LAT-1:0] r_vld;
   logic [CELL_W-1:0]   r_mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_mem_last;
   logic [PTR_W-1:0]    r_wptr, r_rptr;
   logic [CNT_W-1:0]    r_count, w_inflight;
   logic [CELL_W-1:0]   r_cellA, r_cellB;
   logic [OPC_W-1:0]    r_opcode;
   logic [USER_W-1:0]   r_user;
   logic                w_start_ok, w_issue, w_capture, w_pop;

   always_comb begin
      w_inflight = '0;
      for (int unsigned i = 0; i < PROC_LAT; i++)
         w_inflight = w_inflight + CNT_W'(r_vld[i]);
   end

   // Credit covers both stored results and pairs still inside the processor pipeline.
   assign src_ready  = (r_state == S_RUN) && (r_issued < r_len) &&
                       ((r_count + w_inflight) < CNT_W'(FIFO_DEPTH));
   assign w_start_ok = (r_state == S_IDLE) && start;
   assign w_issue    = src_valid && src_ready;
   assign w_capture  = r_vld[PROC_LAT-1];
   assign res_valid  = (r_count != '0);
   assign w_pop      = res_valid && res_ready;
   assign res_data   = r_mem[r_rptr];
   assign res_last   = r_mem_last[r_rptr];
   assign busy       = (r_state != S_IDLE);
   assign done       = (r_state == S_DONE);
   assign cellA      = r_cellA;
   assign cellB      = r_cellB;
   assign opcode     = r_opcode;
   assign userInputA = r_user;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = (job_len != '0) ? S_RUN : S_DONE;
         S_RUN:   if (r_issued == r_len) w_next = S_DRAIN;
         S_DRAIN: if (r_popped == r_len) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_len    <= '0;
         r_issued <= '0;
         r_popped <= '0;
         r_opcode <= '0;
         r_user   <= '0;
         r_cellA  <= '0;
         r_cellB  <= '0;
         r_vld    <= '0;
      end else begin
         r_state <= w_next;
         if (w_start_ok) begin
            r_len    <= job_len;
            r_opcode <= job_opcode;
            r_user   <= job_user;
            r_issued <= '0;
            r_popped <= '0;
         end
         if (w_issue) begin
            r_cellA  <= src_a;
            r_cellB  <= src_b;
            r_issued <= r_issued + 1'b1;
         end
         if (w_pop)
            r_popped <= r_popped + 1'b1;
         r_vld <= PROC_LAT'({r_vld, w_issue});
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++)
            r_mem[i] <= '0;
         r_mem_last <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_capidx   <= '0;
      end else begin
         if (w_start_ok)
            r_capidx <= '0;
         if (w_capture) begin
            r_mem[r_wptr]      <= processedCell;
            r_mem_last[r_wptr] <= (r_capidx == r_len - LEN_W'(1));
            r_wptr             <= r_wptr + 1'b1;
            r_capidx           <= r_capidx + 1'b1;
         end
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         case ({w_capture, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_image_cell_feeder.sv
// Directed and randomized checks of image_cell_feeder at PROC_LAT 2 (directed), 1 and 8 (random).
module tb_image_cell_feeder;
   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       start [NI];
   logic [3:0] job_opcode [NI];
   logic [7:0] job_user [NI];
   logic [15:0] job_len [NI];
   logic       busy [NI], done [NI], src_valid [NI], src_ready [NI];
   logic [7:0] src_a [NI], src_b [NI], cellA [NI], cellB [NI], userInputA [NI];
   logic [3:0] opcode [NI];
   logic [7:0] proc [NI], res_data [NI];
   logic       res_valid [NI], res_ready [NI], res_last [NI];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < NI; k++) begin : g
      localparam int unsigned L = (k == 0) ? 2 : (k == 1) ? 1 : 8;
      logic [7:0] pp [8];

      image_cell_feeder #(.CELL_W(8), .LEN_W(16), .PROC_LAT(L), .FIFO_DEPTH(4),
                          .OPC_W(4), .USER_W(8)) dut (
         .clk(clk), .rst(rst), .start(start[k]), .job_opcode(job_opcode[k]),
         .job_user(job_user[k]), .job_len(job_len[k]), .busy(busy[k]), .done(done[k]),
         .src_valid(src_valid[k]), .src_ready(src_ready[k]), .src_a(src_a[k]),
         .src_b(src_b[k]), .cellA(cellA[k]), .cellB(cellB[k]), .userInputA(userInputA[k]),
         .opcode(opcode[k]), .processedCell(proc[k]), .res_valid(res_valid[k]),
         .res_ready(res_ready[k]), .res_data(res_data[k]), .res_last(res_last[k])
      );

      // Cell processor model: A+B with L-1 register stages so the sum is valid L edges after issue.
      always @(posedge clk) begin
         pp[0] <= cellA[k] + cellB[k];
         for (int j = 1; j < 8; j++) pp[j] <= pp[j-1];
      end
      assign proc[k] = (L == 1) ? 8'(cellA[k] + cellB[k]) : pp[(L >= 2) ? L - 2 : 0];
   end

   task automatic test_reset;
      int bad_cnt;
      checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy[0]); end
      checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b expected 0", done[0]); end
      checks++; if ({src_ready[0], res_valid[0], res_last[0]} !== 3'b000) begin errors++;
         $display("FAIL rst_flags: got %b expected 000", {src_ready[0], res_valid[0], res_last[0]}); end
      checks++; if ({cellA[0], cellB[0], opcode[0], userInputA[0], res_data[0]} !== 36'h0) begin errors++;
         $display("FAIL rst_data: got %h expected 0", {cellA[0], cellB[0], opcode[0], userInputA[0], res_data[0]}); end
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      start[0] = 1'b1; job_len[0] = 16'd4; job_opcode[0] = 4'd5; job_user[0] = 8'h33;
      @(negedge clk) start[0] = 1'b0;
      src_valid[0] = 1'b1; src_a[0] = 8'd1; src_b[0] = 8'd2;
      @(negedge clk) src_a[0] = 8'd3; src_b[0] = 8'd4;
      @(negedge clk) src_valid[0] = 1'b0;
      checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL midjob_busy: got %0b expected 1", busy[0]); end
      #2 rst = 1'b0;
      #1;
      checks++; if ({busy[0], done[0], src_ready[0], res_valid[0], res_last[0]} !== 5'b0) begin errors++;
         $display("FAIL abort_flags: got %b expected 00000", {busy[0], done[0], src_ready[0], res_valid[0], res_last[0]}); end
      checks++; if ({cellA[0], cellB[0], opcode[0], userInputA[0], res_data[0]} !== 36'h0) begin errors++;
         $display("FAIL abort_data: got %h expected 0", {cellA[0], cellB[0], opcode[0], userInputA[0], res_data[0]}); end
      @(negedge clk) rst = 1'b1;
      bad_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); #1;
         if (res_valid[0] || done[0] || busy[0]) bad_cnt++;
      end
      checks++; if (bad_cnt !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", bad_cnt); end
   endtask

   task automatic test_basic;
      logic [7:0] exp [4];
      int iss_cyc [4];
      int ni, nr, ndone;
      exp[0] = 8'd3; exp[1] = 8'd7; exp[2] = 8'd11; exp[3] = 8'd15;
      ni = 0; nr = 0; ndone = 0;
      @(negedge clk);
      start[0] = 1'b1; job_len[0] = 16'd4; job_opcode[0] = 4'd3; job_user[0] = 8'h5A; res_ready[0] = 1'b1;
      @(negedge clk) start[0] = 1'b0;
      checks++; if (opcode[0] !== 4'd3) begin errors++; $display("FAIL basic_opcode: got %0d expected 3", opcode[0]); end
      checks++; if (userInputA[0] !== 8'h5A) begin errors++; $display("FAIL basic_user: got %h expected 5a", userInputA[0]); end
      for (int c = 0; c < 25; c++) begin
         if (ni < 4) begin
            src_valid[0] = 1'b1; src_a[0] = 8'(2*ni + 1); src_b[0] = 8'(2*ni + 2);
         end else src_valid[0] = 1'b0;
         #1;
         if (done[0]) ndone++;
         if (res_valid[0]) begin
            if (nr < 4) begin
               checks++; if (res_data[0] !== exp[nr]) begin errors++; $display("FAIL basic_data[%0d]: got %0d expected %0d", nr, res_data[0], exp[nr]); end
               checks++; if (res_last[0] !== (nr == 3)) begin errors++; $display("FAIL basic_last[%0d]: got %0b expected %0b", nr, res_last[0], nr == 3); end
               checks++; if (c !== iss_cyc[nr] + 3) begin errors++; $display("FAIL basic_latency[%0d]: got cycle %0d expected %0d", nr, c, iss_cyc[nr] + 3); end
            end
            nr++;
         end
         if (src_valid[0] && src_ready[0]) begin
            if (ni < 4) iss_cyc[ni] = c;
            ni++;
         end
         @(negedge clk);
      end
      checks++; if (nr !== 4) begin errors++; $display("FAIL basic_count: got %0d expected 4", nr); end
      checks++; if (iss_cyc[3] !== iss_cyc[0] + 3) begin errors++; $display("FAIL back_to_back: got span %0d expected 3", iss_cyc[3] - iss_cyc[0]); end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL basic_done: got %0d pulses expected 1", ndone); end
      checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy %0b expected 0", busy[0]); end
   endtask

   task automatic test_backpressure;
      int ni, nr, ndone;
      ni = 0; nr = 0; ndone = 0;
      @(negedge clk);
      start[0] = 1'b1; job_len[0] = 16'd8; res_ready[0] = 1'b0;
      @(negedge clk) start[0] = 1'b0;
      for (int c = 0; c < 12; c++) begin
         src_valid[0] = (ni < 8); src_a[0] = 8'(16 + ni); src_b[0] = 8'(3 * ni);
         #1;
         if (src_valid[0] && src_ready[0]) ni++;
         @(negedge clk);
      end
      src_a[0] = 8'(16 + ni); src_b[0] = 8'(3 * ni);
      #1;
      checks++; if (ni !== 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", ni); end
      checks++; if (src_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_ready: got %0b expected 0", src_ready[0]); end
      checks++; if (res_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b expected 1", res_valid[0]); end
      @(negedge clk);
      res_ready[0] = 1'b1;
      for (int c = 0; c < 60 && (nr < 8 || busy[0]); c++) begin
         src_valid[0] = (ni < 8); src_a[0] = 8'(16 + ni); src_b[0] = 8'(3 * ni);
         #1;
         if (done[0]) ndone++;
         if (res_valid[0] && res_ready[0]) begin
            checks++; if (res_data[0] !== 8'(16 + 4*nr)) begin errors++; $display("FAIL bp_data[%0d]: got %0d expected %0d", nr, res_data[0], 16 + 4*nr); end
            checks++; if (res_last[0] !== (nr == 7)) begin errors++; $display("FAIL bp_last[%0d]: got %0b expected %0b", nr, res_last[0], nr == 7); end
            nr++;
         end
         if (src_valid[0] && src_ready[0]) ni++;
         @(negedge clk);
      end
      src_valid[0] = 1'b0;
      checks++; if (nr !== 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", nr); end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL bp_done: got %0d pulses expected 1", ndone); end
   endtask

   task automatic test_zero_len;
      @(negedge clk);
      start[0] = 1'b1; job_len[0] = 16'd0; src_valid[0] = 1'b1;
      @(negedge clk) start[0] = 1'b0;
      #1;
      checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL zero_done: got %0b expected 1", done[0]); end
      checks++; if ({src_ready[0], res_valid[0]} !== 2'b00) begin errors++; $display("FAIL zero_quiet: got %b expected 00", {src_ready[0], res_valid[0]}); end
      @(negedge clk); #1;
      checks++; if ({done[0], busy[0], src_ready[0], res_valid[0]} !== 4'b0) begin errors++;
         $display("FAIL zero_after: got %b expected 0000", {done[0], busy[0], src_ready[0], res_valid[0]}); end
      src_valid[0] = 1'b0;
   endtask

   task automatic test_start_ignored;
      int ni, nr, ndone;
      ni = 0; nr = 0; ndone = 0;
      @(negedge clk);
      start[0] = 1'b1; job_len[0] = 16'd3; job_opcode[0] = 4'd6; job_user[0] = 8'h11; res_ready[0] = 1'b1;
      @(negedge clk) start[0] = 1'b0;
      repeat (2) @(negedge clk);
      start[0] = 1'b1; job_len[0] = 16'd7; job_opcode[0] = 4'd9; job_user[0] = 8'h77;
      @(negedge clk) start[0] = 1'b0;
      #1;
      checks++; if (opcode[0] !== 4'd6) begin errors++; $display("FAIL ign_opcode: got %0d expected 6", opcode[0]); end
      checks++; if (userInputA[0] !== 8'h11) begin errors++; $display("FAIL ign_user: got %h expected 11", userInputA[0]); end
      for (int c = 0; c < 40 && (c < 2 || busy[0]); c++) begin
         src_valid[0] = 1'b1; src_a[0] = 8'(ni); src_b[0] = 8'd100;
         #1;
         if (done[0]) ndone++;
         if (res_valid[0] && res_ready[0]) begin
            checks++; if (res_data[0] !== 8'(100 + nr)) begin errors++; $display("FAIL ign_data[%0d]: got %0d expected %0d", nr, res_data[0], 100 + nr); end
            nr++;
         end
         if (src_valid[0] && src_ready[0]) ni++;
         @(negedge clk);
      end
      src_valid[0] = 1'b0;
      checks++; if (ni !== 3) begin errors++; $display("FAIL ign_issued: got %0d expected 3", ni); end
      checks++; if (nr !== 3) begin errors++; $display("FAIL ign_results: got %0d expected 3", nr); end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL ign_done: got %0d pulses expected 1", ndone); end
   endtask

   task automatic test_random(input int k);
      logic [7:0] q [$];
      logic [7:0] e;
      int ni, nr, ndone, nlast;
      ni = 0; nr = 0; ndone = 0; nlast = 0;
      @(negedge clk);
      start[k] = 1'b1; job_len[k] = 16'd1000; job_opcode[k] = 4'(k); job_user[k] = 8'hC0;
      @(negedge clk) start[k] = 1'b0;
      for (int c = 0; c < 20000 && (nr < 1000 || busy[k]); c++) begin
         src_valid[k] = (ni < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         src_a[k] = 8'($urandom); src_b[k] = 8'($urandom);
         res_ready[k] = 1'($urandom_range(0, 1));
         #1;
         if (done[k]) ndone++;
         if (res_valid[k] && res_ready[k]) begin
            if (res_last[k]) nlast++;
            if (q.size() == 0) begin
               checks++; errors++; $display("FAIL rnd%0d_spurious: got result %0d expected none", k, res_data[k]);
            end else begin
               e = q.pop_front();
               checks++; if (res_data[k] !== e) begin errors++; $display("FAIL rnd%0d_data[%0d]: got %0d expected %0d", k, nr, res_data[k], e); end
               checks++; if (res_last[k] !== (nr == 999)) begin errors++; $display("FAIL rnd%0d_last[%0d]: got %0b expected %0b", k, nr, res_last[k], nr == 999); end
            end
            nr++;
         end
         if (src_valid[k] && src_ready[k]) begin
            q.push_back(8'(src_a[k] + src_b[k]));
            ni++;
         end
         @(negedge clk);
      end
      src_valid[k] = 1'b0; res_ready[k] = 1'b0;
      checks++; if (nr !== 1000) begin errors++; $display("FAIL rnd%0d_count: got %0d expected 1000", k, nr); end
      checks++; if (nlast !== 1) begin errors++; $display("FAIL rnd%0d_lastcnt: got %0d expected 1", k, nlast); end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL rnd%0d_done: got %0d pulses expected 1", k, ndone); end
      checks++; if (busy[k] !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle: got busy %0b expected 0", k, busy[k]); end
   endtask

   initial begin
      rst = 1'b0;
      for (int k = 0; k < NI; k++) begin
         start[k] = 1'b0; job_opcode[k] = '0; job_user[k] = '0; job_len[k] = '0;
         src_valid[k] = 1'b0; src_a[k] = '0; src_b[k] = '0; res_ready[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      test_reset;
      test_basic;
      test_backpressure;
      test_zero_len;
      test_start_ignored;
      test_random(1);
      test_random(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
